// File: rtl/seg7_pkg.sv
// Shared segment types and the hex-to-segment table for the 7-segment scanner.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // {g,f,e,d,c,b,a}, active low, common anode
    localparam seg_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex2seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_controller.sv
// N-digit multiplexed 7-segment driver with leading-zero blanking.
// Define SEG7_DP_EN to add per-digit decimal point input dp and output dp_n.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  lz_blank,
`ifdef SEG7_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  dp_n,
`endif
    output seg_t                  seg_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    seg_t                  seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic [DIGITS-1:0]     blank;
    logic                  zeros;
    logic                  cur_blank;
    logic [3:0]            nib;
    seg_t                  hex_seg;

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    assign shadow_d = load ? value : shadow_q;

    // Walk down from the top digit; a digit is blank while everything above it is zero
    always_comb begin
        zeros = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeros = zeros & (shadow_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                blank[i] = lz_blank & zeros;
            end
        end
    end

    always_comb begin
        nib       = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib       = shadow_q[4*i +: 4];
                cur_blank = blank[i];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (nib),
        .seg    (hex_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (enable) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            if (!cur_blank) begin
                seg_d = hex_seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] dp_shadow_q, dp_shadow_d;
    logic              dp_q, dp_d;
    logic              dp_cur;

    assign dp_shadow_d = load ? dp : dp_shadow_q;

    always_comb begin
        dp_cur = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dp_cur = dp_shadow_q[i];
            end
        end
        dp_d = !(enable && !cur_blank && dp_cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_shadow_q <= '0;
            dp_q        <= 1'b1;
        end else begin
            dp_shadow_q <= dp_shadow_d;
            dp_q        <= dp_d;
        end
    end

    assign dp_n = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller, DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic        lz_blank;
    logic [3:0]  dp;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
`ifdef SEG7_DP_EN
    logic        dp_n;
`endif

    always #5 clk = ~clk;

    seg7_scan_controller #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .enable   (enable),
        .lz_blank (lz_blank),
`ifdef SEG7_DP_EN
        .dp       (dp),
        .dp_n     (dp_n),
`endif
        .seg_n    (seg_n),
        .an_n     (an_n)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        int         tag;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   tests = 0;
    int   fails = 0;
    int   tag   = 0;
    int   edge_n = 0;

    task automatic tick(input logic [3:0] an, input logic [6:0] seg,
                        input logic dpn);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.dpn = dpn;
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] an, input logic [6:0] seg,
                       input logic dpn, input int n);
        for (int k = 0; k < n; k++) tick(an, seg, dpn);
    endtask

    function automatic logic dpx(input logic [6:0] s, input logic b);
        return (s == 7'h7F) ? 1'b1 : ~b;
    endfunction

    // Reset mid-scan, load at the first edge, then one full scan and a wrap
    task automatic scan_check(input logic [15:0] v, input logic lz,
                              input logic [3:0] dv,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        rst_n = 1'b0;
        load  = 1'b0;
        tick(4'hF, 7'h7F, 1'b1);
        rst_n    = 1'b1;
        load     = 1'b1;
        value    = v;
        lz_blank = lz;
        dp       = dv;
        tick(4'hE, 7'h40, 1'b1);
        load  = 1'b0;
        value = ~v;
        dp    = ~dv;
        run(4'hE, s0, dpx(s0, dv[0]), 3);
        run(4'hD, s1, dpx(s1, dv[1]), 4);
        run(4'hB, s2, dpx(s2, dv[2]), 4);
        run(4'h7, s3, dpx(s3, dv[3]), 4);
        run(4'hE, s0, dpx(s0, dv[0]), 4);
    endtask

    always @(posedge clk) begin
        #1;
        edge_n++;
        if (q.size() > 0) begin
            m = q.pop_front();
            tests++;
            if (an_n !== m.an || seg_n !== m.seg) begin
                fails++;
                $display("FAIL scan t%0d edge %0d: an_n=%h seg_n=%h, want an_n=%h seg_n=%h",
                         m.tag, edge_n, an_n, seg_n, m.an, m.seg);
            end
`ifdef SEG7_DP_EN
            tests++;
            if (dp_n !== m.dpn) begin
                fails++;
                $display("FAIL dp t%0d edge %0d: dp_n=%b, want %b",
                         m.tag, edge_n, dp_n, m.dpn);
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        value    = 16'h0;
        load     = 1'b0;
        enable   = 1'b1;
        lz_blank = 1'b0;
        dp       = 4'h0;
        @(negedge clk);

        tag = 1;
        for (int i = 0; i < 4; i++) begin
            value    = 16'hA5A5 ^ 16'(i);
            load     = (i % 2) == 0;
            enable   = (i % 2) == 1;
            lz_blank = (i > 1);
            dp       = 4'(i);
            tick(4'hF, 7'h7F, 1'b1);
        end
        rst_n    = 1'b1;
        load     = 1'b0;
        enable   = 1'b1;
        lz_blank = 1'b0;
        value    = 16'h0;
        dp       = 4'h0;
        tick(4'hE, 7'h40, 1'b1);

        tag   = 2;
        load  = 1'b1;
        value = 16'h1234;
        tick(4'hE, 7'h40, 1'b1);
        load  = 1'b0;
        value = 16'hFFFF;
        run(4'hE, 7'h19, 1'b1, 2);
        run(4'hD, 7'h30, 1'b1, 4);
        run(4'hB, 7'h24, 1'b1, 4);
        run(4'h7, 7'h79, 1'b1, 4);
        run(4'hE, 7'h19, 1'b1, 4);
        run(4'hD, 7'h30, 1'b1, 4);

        tag      = 3;
        load     = 1'b1;
        value    = 16'h00A0;
        lz_blank = 1'b1;
        tick(4'hB, 7'h24, 1'b1);
        load  = 1'b0;
        value = 16'h0;
        run(4'hB, 7'h7F, 1'b1, 3);
        run(4'h7, 7'h7F, 1'b1, 4);
        run(4'hE, 7'h40, 1'b1, 4);
        run(4'hD, 7'h08, 1'b1, 4);
        lz_blank = 1'b0;
        run(4'hB, 7'h40, 1'b1, 4);
        run(4'h7, 7'h40, 1'b1, 4);
        run(4'hE, 7'h40, 1'b1, 4);
        run(4'hD, 7'h08, 1'b1, 4);

        tag = 4;
        tick(4'hB, 7'h40, 1'b1);
        enable = 1'b0;
        run(4'hF, 7'h7F, 1'b1, 2);
        enable = 1'b1;
        tick(4'hB, 7'h40, 1'b1);
        run(4'h7, 7'h40, 1'b1, 2);
        enable = 1'b0;
        run(4'hF, 7'h7F, 1'b1, 3);
        enable = 1'b1;
        run(4'hE, 7'h40, 1'b1, 3);
        run(4'hD, 7'h08, 1'b1, 4);

        tag = 5;
        tick(4'hB, 7'h40, 1'b1);
        load  = 1'b1;
        value = 16'hFFFF;
        tick(4'hB, 7'h40, 1'b1);
        load  = 1'b0;
        value = 16'h0;
        run(4'hB, 7'h0E, 1'b1, 2);
        run(4'h7, 7'h0E, 1'b1, 4);

        tag = 6;
        scan_check(16'h5678, 1'b0, 4'b0101, 7'h00, 7'h78, 7'h02, 7'h12);
        tag = 7;
        scan_check(16'hCDE9, 1'b0, 4'b0000, 7'h10, 7'h06, 7'h21, 7'h46);
        tag = 8;
        scan_check(16'h03AB, 1'b1, 4'b0000, 7'h03, 7'h08, 7'h30, 7'h7F);
        tag = 9;
        scan_check(16'h1000, 1'b1, 4'b0000, 7'h40, 7'h40, 7'h40, 7'h79);
        tag = 10;
        scan_check(16'h0000, 1'b1, 4'b1111, 7'h40, 7'h7F, 7'h7F, 7'h7F);

        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected outputs left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
